data_interpreter: RTL and testbench

- Front-end decoder for the Basys3 calculator.
- Takes a stream of keyboard character codes and detects each newly presented character.
- Classifies each new character as digit, operator, command or invalid.
- Accumulates decimal digits into a binary operand, latches the selected operation mode, and raises a print strobe for the display/compute stage downstream.

---
 rtl/calc_pkg.sv | 52 +++++
 rtl/ascii_classify.sv | 56 +++++
 rtl/data_interpreter.sv | 113 +++++++++++
 tb/tb_data_interpreter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared encodings for the calculator keyboard front end
package calc_pkg;

    localparam int MAX_DIGITS_DEF = 3;

    typedef enum logic [2:0] {
        MODE_NONE = 3'd0,
        MODE_ADD  = 3'd1,
        MODE_SUB  = 3'd2,
        MODE_MUL  = 3'd3,
        MODE_DIV  = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        VC_IDLE = 2'b00,
        VC_OK   = 2'b01,
        VC_OVF  = 2'b10,
        VC_INV  = 2'b11
    } vc_e;

    typedef enum logic [2:0] {
        CL_NONE,
        CL_DIGIT,
        CL_OP,
        CL_BS,
        CL_PRINT,
        CL_CLEAR,
        CL_INV
    } class_e;

    typedef struct packed {
        class_e     cls;
        logic [3:0] digit;
        mode_e      mode;
    } char_info_t;

    localparam logic [6:0] CH_BS    = 7'd8;
    localparam logic [6:0] CH_ENTER = 7'd13;
    localparam logic [6:0] CH_EQ    = 7'd61;
    localparam logic [6:0] CH_ZERO  = 7'd48;
    localparam logic [6:0] CH_NINE  = 7'd57;
    localparam logic [6:0] CH_PLUS  = 7'd43;
    localparam logic [6:0] CH_MINUS = 7'd45;
    localparam logic [6:0] CH_STAR  = 7'd42;
    localparam logic [6:0] CH_SLASH = 7'd47;
    localparam logic [6:0] CH_A     = 7'd97;
    localparam logic [6:0] CH_S     = 7'd115;
    localparam logic [6:0] CH_M     = 7'd109;
    localparam logic [6:0] CH_D     = 7'd100;
    localparam logic [6:0] CH_C     = 7'd99;

endpackage

// File: rtl/ascii_classify.sv
// rtl/ascii_classify.sv - combinational character classifier
module ascii_classify
    import calc_pkg::*;
(
    input  logic [12:0] ascii_in,
    output char_info_t  info
);

    logic [6:0] code;
    logic [6:0] folded;
    logic [6:0] digit_off;

    always_comb begin
        code      = ascii_in[6:0];
        digit_off = code - CH_ZERO;
        // uppercase letters fold onto lowercase so one table serves both
        folded    = (code >= 7'd65 && code <= 7'd90) ? (code | 7'h20) : code;

        info.cls   = CL_INV;
        info.digit = 4'd0;
        info.mode  = MODE_NONE;

        if (ascii_in == 13'd0) begin
            info.cls = CL_NONE;
        end else if (ascii_in[12:7] != 6'd0) begin
            info.cls = CL_INV;
        end else if (code >= CH_ZERO && code <= CH_NINE) begin
            info.cls   = CL_DIGIT;
            info.digit = digit_off[3:0];
        end else begin
            case (folded)
                CH_A, CH_PLUS: begin
                    info.cls  = CL_OP;
                    info.mode = MODE_ADD;
                end
                CH_S, CH_MINUS: begin
                    info.cls  = CL_OP;
                    info.mode = MODE_SUB;
                end
                CH_M, CH_STAR: begin
                    info.cls  = CL_OP;
                    info.mode = MODE_MUL;
                end
                CH_D, CH_SLASH: begin
                    info.cls  = CL_OP;
                    info.mode = MODE_DIV;
                end
                CH_BS:           info.cls = CL_BS;
                CH_ENTER, CH_EQ: info.cls = CL_PRINT;
                CH_C:            info.cls = CL_CLEAR;
                default:         info.cls = CL_INV;
            endcase
        end
    end

endmodule

// File: rtl/data_interpreter.sv
// rtl/data_interpreter.sv - keyboard character decoder and operand accumulator
module data_interpreter
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] ASCII_in,
    output logic [2:0]  modeSelect,
    output logic [1:0]  validCheck,
    output logic [9:0]  numOut,
    output logic        printEnable
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    char_info_t  info;
    logic [12:0] last_code_q, last_code_d;
    logic [CW-1:0] digit_cnt_q, digit_cnt_d;
    logic        new_entry_q, new_entry_d;
    mode_e       mode_q, mode_d;
    vc_e         vc_q, vc_d;
    logic [9:0]  num_q, num_d;
    logic        print_q, print_d;
    logic        process;

    ascii_classify u_classify (
        .ascii_in (ASCII_in),
        .info     (info)
    );

    assign process = (ASCII_in != last_code_q) && (info.cls != CL_NONE);

    always_comb begin
        last_code_d = ASCII_in;
        digit_cnt_d = digit_cnt_q;
        new_entry_d = new_entry_q;
        mode_d      = mode_q;
        vc_d        = vc_q;
        num_d       = num_q;
        print_d     = 1'b0;

        if (process) begin
            case (info.cls)
                CL_DIGIT: begin
                    vc_d = VC_OK;
                    if (new_entry_q) begin
                        num_d       = {6'd0, info.digit};
                        digit_cnt_d = CW'(1);
                        new_entry_d = 1'b0;
                    end else if (digit_cnt_q < CW'(MAX_DIGITS)) begin
                        // digit_cnt below the limit bounds num_q*10+d within 10 bits
                        num_d       = num_q * 10'd10 + {6'd0, info.digit};
                        digit_cnt_d = digit_cnt_q + CW'(1);
                    end else begin
                        vc_d = VC_OVF;
                    end
                end
                CL_OP: begin
                    mode_d      = info.mode;
                    vc_d        = VC_OK;
                    new_entry_d = 1'b1;
                end
                CL_BS: begin
                    num_d = num_q / 10'd10;
                    if (digit_cnt_q != '0)
                        digit_cnt_d = digit_cnt_q - CW'(1);
                    vc_d = VC_OK;
                end
                CL_PRINT: begin
                    print_d     = 1'b1;
                    vc_d        = VC_OK;
                    new_entry_d = 1'b1;
                end
                CL_CLEAR: begin
                    num_d       = 10'd0;
                    mode_d      = MODE_NONE;
                    digit_cnt_d = '0;
                    new_entry_d = 1'b1;
                    vc_d        = VC_OK;
                end
                default: vc_d = VC_INV;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_code_q <= 13'd0;
            digit_cnt_q <= '0;
            new_entry_q <= 1'b1;
            mode_q      <= MODE_NONE;
            vc_q        <= VC_IDLE;
            num_q       <= 10'd0;
            print_q     <= 1'b0;
        end else begin
            last_code_q <= last_code_d;
            digit_cnt_q <= digit_cnt_d;
            new_entry_q <= new_entry_d;
            mode_q      <= mode_d;
            vc_q        <= vc_d;
            num_q       <= num_d;
            print_q     <= print_d;
        end
    end

    assign modeSelect  = mode_q;
    assign validCheck  = vc_q;
    assign numOut      = num_q;
    assign printEnable = print_q;

endmodule

// File: tb/tb_data_interpreter.sv
// tb/tb_data_interpreter.sv - randomized self-checking bench for data_interpreter
module tb_data_interpreter;

    logic        clk;
    logic        rst;
    logic [12:0] ASCII_in;
    logic [2:0]  modeSelect;
    logic [1:0]  validCheck;
    logic [9:0]  numOut;
    logic        printEnable;

    int n_tests;
    int n_fail;

    // reference state, plain integers
    int m_mode, m_vc, m_num, m_cnt, m_fresh, m_last, m_pe;

    data_interpreter dut (
        .clk         (clk),
        .rst         (rst),
        .ASCII_in    (ASCII_in),
        .modeSelect  (modeSelect),
        .validCheck  (validCheck),
        .numOut      (numOut),
        .printEnable (printEnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_mode"}, {29'd0, modeSelect}, m_mode);
        check({tag, "_vc"},   {30'd0, validCheck}, m_vc);
        check({tag, "_num"},  {22'd0, numOut},     m_num);
        check({tag, "_pe"},   {31'd0, printEnable}, m_pe);
    endtask

    function automatic void model_reset();
        m_mode = 0; m_vc = 0; m_num = 0; m_cnt = 0; m_fresh = 1; m_last = 0; m_pe = 0;
    endfunction

    function automatic int op_mode(input int c);
        case (c)
            97, 65, 43:  return 1;
            115, 83, 45: return 2;
            109, 77, 42: return 3;
            100, 68, 47: return 4;
            default:     return 0;
        endcase
    endfunction

    function automatic void model_edge(input int code);
        m_pe = 0;
        if (code != m_last && code != 0) begin
            if (code > 127) begin
                m_vc = 3;
            end else if (code >= 48 && code <= 57) begin
                if (m_fresh != 0) begin
                    m_num = code - 48; m_cnt = 1; m_fresh = 0; m_vc = 1;
                end else if (m_cnt < 3) begin
                    m_num = m_num * 10 + (code - 48); m_cnt++; m_vc = 1;
                end else begin
                    m_vc = 2;
                end
            end else if (op_mode(code) != 0) begin
                m_mode = op_mode(code); m_vc = 1; m_fresh = 1;
            end else if (code == 8) begin
                m_num = m_num / 10;
                if (m_cnt > 0) m_cnt--;
                m_vc = 1;
            end else if (code == 13 || code == 61) begin
                m_pe = 1; m_vc = 1; m_fresh = 1;
            end else if (code == 99 || code == 67) begin
                m_num = 0; m_mode = 0; m_cnt = 0; m_fresh = 1; m_vc = 1;
            end else begin
                m_vc = 3;
            end
        end
        m_last = code;
    endfunction

    // present a code at the falling edge, clock it in, compare at the next falling edge
    task automatic step(input int code, input string tag);
        ASCII_in = 13'(code);
        model_edge(code);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    // assert reset between edges; outputs must clear before the next rising edge
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int op_tab[16] = '{97, 65, 43, 115, 83, 45, 109, 77, 42, 100, 68, 47, 99, 67, 13, 61};

    initial begin
        int code;
        int r;
        int prev;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        ASCII_in = 13'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        step(51, "t1a");
        check("t1a_num_const", {22'd0, numOut}, 3);
        step(54, "t1b");
        check("t1b_num_const", {22'd0, numOut}, 36);
        step(115, "t1c");
        check("t1c_mode_const", {29'd0, modeSelect}, 2);

        step(55, "t2a");
        check("t2a_num_const", {22'd0, numOut}, 7);
        step(13, "t2b");
        check("t2b_pe_const", {31'd0, printEnable}, 1);
        step(13, "t2c");
        check("t2c_pe_clear", {31'd0, printEnable}, 0);

        step(49, "t3a"); step(50, "t3b"); step(51, "t3c"); step(52, "t3d");
        check("t3_num_const", {22'd0, numOut}, 123);
        check("t3_vc_ovf", {30'd0, validCheck}, 2);

        step(99, "t4clr");
        step(53, "t4a"); step(0, "t4nul"); step(53, "t4b");
        for (int i = 0; i < 5; i++) step(53, "t4hold");
        check("t4_num_const", {22'd0, numOut}, 55);

        step(99, "t5clr");
        step(52, "t5a"); step(50, "t5b"); step(8, "t5bs");
        check("t5_bs_const", {22'd0, numOut}, 4);
        step(64, "t5at");
        check("t5_inv_const", {30'd0, validCheck}, 3);
        step(4096, "t5hi");

        step(51, "t6a"); step(54, "t6b"); step(115, "t6c");
        ASCII_in = 13'd57;
        async_reset("t6rst");
        step(57, "t6after");
        check("t6_num_const", {22'd0, numOut}, 9);

        prev = 57;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 19);
            if (r <= 6)       code = 48 + $urandom_range(0, 9);
            else if (r <= 9)  code = op_tab[$urandom_range(0, 15)];
            else if (r == 10) code = 0;
            else if (r <= 12) code = prev;
            else if (r == 13) code = 8;
            else if (r == 14) code = $urandom_range(1, 127);
            else if (r == 15) code = $urandom_range(128, 8191);
            else              code = 0;
            if ($urandom_range(0, 79) == 0) begin
                ASCII_in = 13'(code);
                async_reset("rnd_rst");
            end
            step(code, "rnd");
            prev = code;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
